// File: rtl/cache_way_read_pipe.sv
// Registered way-select stage for the set-associative cache read path.
// Picks one way's line/word/tag/dirty and flags zero-hit and multi-hit selects.
module cache_way_read_pipe #(
    parameter int WAYS            = 4,
    parameter int LINE_SIZE_BYTES = 4,
    parameter int WORD_BYTES      = 4,
    parameter int LRU_BITS        = 1,
    parameter int VALID_BITS      = 1,
    parameter int DIRTY_BITS      = 1,
    parameter int TAG_BITS        = 18,
    parameter int ERR_CNT_BITS    = 8,
    localparam int DATA_W  = LINE_SIZE_BYTES * 8,
    localparam int WORD_W  = WORD_BYTES * 8,
    localparam int ENTRY_W = VALID_BITS + LRU_BITS + DIRTY_BITS
                           + TAG_BITS + DATA_W,
    localparam int WORDS   = LINE_SIZE_BYTES / WORD_BYTES,
    localparam int WSEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WAYS*ENTRY_W-1:0]   i_data,
    input  logic [WAYS-1:0]           i_sel,
    input  logic [WSEL_W-1:0]         i_word_sel,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_line,
    output logic [WORD_W-1:0]         o_word,
    output logic [TAG_BITS-1:0]       o_tag,
    output logic [DIRTY_BITS-1:0]     o_dirty,
    output logic [WAYS-1:0]           o_way,
    output logic                      o_hit,
    output logic                      o_multi_hit,
    output logic [ERR_CNT_BITS-1:0]   o_err_count
);

    localparam int TAG_LO   = DATA_W;
    localparam int DIRTY_LO = TAG_LO + TAG_BITS;
    localparam int LRU_LO   = DIRTY_LO + DIRTY_BITS;
    localparam int VALID_LO = LRU_LO + LRU_BITS;

    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       line_q, line_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [TAG_BITS-1:0]     tag_q, tag_d;
    logic [DIRTY_BITS-1:0]   dirty_q, dirty_d;
    logic [WAYS-1:0]         way_q;
    logic                    hit_q, hit_d;
    logic                    multi_q, multi_d;
    logic [ERR_CNT_BITS-1:0] err_q, err_d;

    logic [ENTRY_W-1:0]      sel_entry;
    logic                    one_hot;
    logic                    accept;
    logic                    unused_fields;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;

    // LRU and upper valid bits are carried in the entry but not needed here.
    assign unused_fields = ^sel_entry[ENTRY_W-1:LRU_LO];

    // Decode the select vector; a non-one-hot select returns zeroed fields.
    always_comb begin
        sel_entry = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (i_sel[w]) begin
                sel_entry = sel_entry | i_data[w*ENTRY_W +: ENTRY_W];
            end
        end
        multi_d = (i_sel & (i_sel - WAYS'(1))) != '0;
        one_hot = (i_sel != '0) && !multi_d;
        line_d  = one_hot ? sel_entry[DATA_W-1:0] : '0;
        tag_d   = one_hot ? sel_entry[TAG_LO +: TAG_BITS] : '0;
        dirty_d = one_hot ? sel_entry[DIRTY_LO +: DIRTY_BITS] : '0;
        hit_d   = one_hot && sel_entry[VALID_LO];
    end

    // Pick the requested word; an out-of-range index yields zero.
    always_comb begin
        word_d = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (i_word_sel == WSEL_W'(k)) begin
                word_d = line_d[k*WORD_W +: WORD_W];
            end
        end
    end

    // Response valid and saturating multi-hit counter next-state.
    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
        err_d = err_q;
        if (accept && multi_d && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_BITS'(1);
        end
    end

    // Output registers load only on accept; reset discards any response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            line_q  <= '0;
            word_q  <= '0;
            tag_q   <= '0;
            dirty_q <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            if (accept) begin
                line_q  <= line_d;
                word_q  <= word_d;
                tag_q   <= tag_d;
                dirty_q <= dirty_d;
                way_q   <= i_sel;
                hit_q   <= hit_d;
                multi_q <= multi_d;
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_line      = line_q;
    assign o_word      = word_q;
    assign o_tag       = tag_q;
    assign o_dirty     = dirty_q;
    assign o_way       = way_q;
    assign o_hit       = hit_q;
    assign o_multi_hit = multi_q;
    assign o_err_count = err_q;

endmodule
